stream_fifo: RTL and testbench

- Parametrised synchronous FIFO; successor to the fixed single-mode FIFO.
- Adds arbitrary (non-power-of-two) depth and a selectable first-word-fall-through or request/response read mode.
- Adds occupancy count, programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags.
- Sits between any two valid/ready stream stages in the design as a rate-decoupling buffer.

---
 rtl/stream_fifo.sv | 126 ++++++++++++
 tb/tb_stream_fifo.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo.sv
// Parametrised synchronous FIFO with arbitrary depth, FWFT or request/response
// read mode, occupancy count, programmable almost flags and sticky error flags.
module stream_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter bit FWFT     = 1'b1,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       ready_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       valid_o,
  output logic                       is_full_o,
  output logic                       is_empty_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  if (DEPTH < 2) begin : g_bad_depth
    $error("stream_fifo: DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("stream_fifo: AF_LEVEL must be within 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("stream_fifo: AE_LEVEL must be within 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvld_q, rvld_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             full, empty, wr_en, rd_en;

  // Explicit wrap so non-power-of-two depths never touch unused slots.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full       = (count_q == CW'(DEPTH));
    empty      = (count_q == '0);
    wr_en      = valid_i && !full && !flush_i;
    // In FWFT mode valid_o == !empty, so the pop condition matches the request accept.
    rd_en      = ready_i && !empty && !flush_i;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    rdata_d    = rdata_q;
    rvld_d     = 1'b0;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = next_ptr(wr_ptr_q);
      if (rd_en) rd_ptr_d = next_ptr(rd_ptr_q);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (!FWFT && rd_en) begin
        rdata_d = mem_q[rd_ptr_q];
        rvld_d  = 1'b1;
      end
      if (valid_i && full) ovf_d = 1'b1;
      if (!FWFT && ready_i && empty) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvld_q   <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rvld_q   <= rvld_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

  // FWFT head word is forced to zero when empty so reset/idle output is clean.
  assign data_o         = FWFT ? (empty ? '0 : mem_q[rd_ptr_q]) : rdata_q;
  assign valid_o        = FWFT ? !empty : rvld_q;
  assign is_full_o      = full;
  assign is_empty_o     = empty;
  assign almost_full_o  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty_o = (count_q <= CW'(AE_LEVEL));
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo: four configurations driven by directed and random
// steps, every output compared each cycle against a queue-based model.
module tb_stream_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        vin [4];
  logic        rin [4];
  logic        fin [4];
  logic [31:0] din [4];
  logic [31:0] dout [4];
  logic        vout [4];
  logic        full [4];
  logic        empty [4];
  logic        af [4];
  logic        ae [4];
  logic        ovf [4];
  logic        udf [4];
  logic [2:0]  cnt0, cnt1, cnt2;
  logic [3:0]  cnt3;

  int n_vec = 0;
  int n_err = 0;

  // u0: DEPTH=4 FWFT; u1: DEPTH=5 request mode; u2: DEPTH=4 request mode; u3: DEPTH=8 FWFT thresholds
  stream_fifo #(.WIDTH(32), .DEPTH(4), .FWFT(1'b1)) u0 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(fin[0]), .valid_i(vin[0]), .data_i(din[0]),
    .ready_i(rin[0]), .data_o(dout[0]), .valid_o(vout[0]), .is_full_o(full[0]),
    .is_empty_o(empty[0]), .almost_full_o(af[0]), .almost_empty_o(ae[0]),
    .count_o(cnt0), .overflow_o(ovf[0]), .underflow_o(udf[0]));
  stream_fifo #(.WIDTH(32), .DEPTH(5), .FWFT(1'b0)) u1 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(fin[1]), .valid_i(vin[1]), .data_i(din[1]),
    .ready_i(rin[1]), .data_o(dout[1]), .valid_o(vout[1]), .is_full_o(full[1]),
    .is_empty_o(empty[1]), .almost_full_o(af[1]), .almost_empty_o(ae[1]),
    .count_o(cnt1), .overflow_o(ovf[1]), .underflow_o(udf[1]));
  stream_fifo #(.WIDTH(32), .DEPTH(4), .FWFT(1'b0)) u2 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(fin[2]), .valid_i(vin[2]), .data_i(din[2]),
    .ready_i(rin[2]), .data_o(dout[2]), .valid_o(vout[2]), .is_full_o(full[2]),
    .is_empty_o(empty[2]), .almost_full_o(af[2]), .almost_empty_o(ae[2]),
    .count_o(cnt2), .overflow_o(ovf[2]), .underflow_o(udf[2]));
  stream_fifo #(.WIDTH(32), .DEPTH(8), .FWFT(1'b1), .AF_LEVEL(6), .AE_LEVEL(2)) u3 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(fin[3]), .valid_i(vin[3]), .data_i(din[3]),
    .ready_i(rin[3]), .data_o(dout[3]), .valid_o(vout[3]), .is_full_o(full[3]),
    .is_empty_o(empty[3]), .almost_full_o(af[3]), .almost_empty_o(ae[3]),
    .count_o(cnt3), .overflow_o(ovf[3]), .underflow_o(udf[3]));

  function automatic int dep(input int i);
    case (i) 0: return 4; 1: return 5; 2: return 4; default: return 8; endcase
  endfunction
  function automatic bit fw(input int i);
    return (i == 0 || i == 3);
  endfunction
  function automatic int afl(input int i);
    case (i) 0: return 2; 1: return 3; 2: return 2; default: return 6; endcase
  endfunction
  function automatic int cnt(input int i);
    case (i) 0: return 32'(cnt0); 1: return 32'(cnt1); 2: return 32'(cnt2); default: return 32'(cnt3); endcase
  endfunction

  // Reference model: contents as a queue, plus error flags and the registered read word.
  logic [31:0] mq [4][$];
  bit          m_ovf [4];
  bit          m_udf [4];
  bit          m_vld [4];
  logic [31:0] m_dat [4];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      m_ovf[i] = 0; m_udf[i] = 0; m_vld[i] = 0; m_dat[i] = '0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 4; i++) begin
      int sz;
      bit rd, wr;
      logic [31:0] w;
      sz = mq[i].size();
      if (fin[i]) begin
        mq[i].delete();
        m_ovf[i] = 0; m_udf[i] = 0; m_vld[i] = 0;
      end else begin
        rd = rin[i] && (sz > 0);
        wr = vin[i] && (sz < dep(i));
        m_vld[i] = 0;
        if (rd) begin
          w = mq[i].pop_front();
          if (!fw(i)) begin m_dat[i] = w; m_vld[i] = 1; end
        end
        if (vin[i] && sz == dep(i)) m_ovf[i] = 1;
        if (!fw(i) && rin[i] && sz == 0) m_udf[i] = 1;
        if (wr) mq[i].push_back(din[i]);
      end
    end
  endtask

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s u%0d observed %h expected %h", tag, i, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      int sz;
      sz = mq[i].size();
      chk("count", i, cnt(i), sz);
      chk("full", i, full[i], sz == dep(i));
      chk("empty", i, empty[i], sz == 0);
      chk("afull", i, af[i], sz >= afl(i));
      chk("aempty", i, ae[i], sz <= 2);
      chk("overflow", i, ovf[i], m_ovf[i]);
      chk("underflow", i, udf[i], m_udf[i]);
      chk("valid", i, vout[i], fw(i) ? (sz != 0) : m_vld[i]);
      if (!fw(i)) chk("data", i, dout[i], m_dat[i]);
      else if (sz != 0) chk("data", i, dout[i], mq[i][0]);
    end
  endtask

  task automatic idle();
    for (int i = 0; i < 4; i++) begin
      vin[i] = 0; rin[i] = 0; fin[i] = 0; din[i] = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fd [4];
    int exp_v;
    fd[0] = 32'hABCDEFAA; fd[1] = 32'hDEADDEAD; fd[2] = 32'hAAAAAAAA; fd[3] = 32'hDDDDDDDD;
    idle();
    model_reset();
    #1;
    check_all();
    step();
    step();
    rst_n = 1'b1;
    step();

    // Fill/drain on u0
    for (int k = 0; k < 4; k++) begin
      vin[0] = 1; din[0] = fd[k]; step();
    end
    idle();
    chk("fd_full", 0, full[0], 1);
    chk("fd_count", 0, cnt(0), 4);
    rin[0] = 1;
    for (int k = 0; k < 4; k++) begin
      chk("fd_order", 0, dout[0], fd[k]);
      step();
    end
    chk("fd_empty", 0, empty[0], 1);
    idle();

    // Simultaneous access on u0 at count 2, then from empty
    vin[0] = 1;
    for (int k = 0; k < 2; k++) begin din[0] = $urandom; step(); end
    rin[0] = 1;
    for (int k = 0; k < 10; k++) begin
      din[0] = $urandom; step();
      chk("sim_count2", 0, cnt(0), 2);
    end
    idle(); fin[0] = 1; step();
    idle(); vin[0] = 1; rin[0] = 1; din[0] = 32'h5A5A0001; step();
    chk("sim_count1", 0, cnt(0), 1);
    idle(); rin[0] = 1; step();
    idle();

    // Wrap on u1 (DEPTH=5): 12 writes interleaved with requests
    exp_v = 1;
    for (int c = 0; c <= 12; c++) begin
      vin[1] = (c < 12); din[1] = 32'(c + 1);
      rin[1] = (c >= 1);
      step();
      if (vout[1]) begin chk("wrap_data", 1, dout[1], exp_v); exp_v++; end
    end
    chk("wrap_reads", 1, exp_v, 13);
    idle();

    // Overflow / underflow on u2
    for (int k = 0; k < 5; k++) begin
      vin[2] = 1; din[2] = 32'h100 + 32'(k); step();
    end
    idle();
    chk("ovf_set", 2, ovf[2], 1);
    chk("ovf_count", 2, cnt(2), 4);
    step(); step();
    chk("ovf_sticky", 2, ovf[2], 1);
    rin[2] = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("drain_data", 2, dout[2], 32'h100 + 32'(k));
    end
    step();
    chk("udf_set", 2, udf[2], 1);
    chk("udf_valid", 2, vout[2], 0);
    idle(); fin[2] = 1; step();
    chk("flush_ovf", 2, ovf[2], 0);
    chk("flush_udf", 2, udf[2], 0);
    idle();

    // Thresholds on u3: count 0 -> 8 -> 0
    for (int k = 1; k <= 8; k++) begin
      vin[3] = 1; din[3] = $urandom; step();
      chk("thr_af_up", 3, af[3], k >= 6);
      chk("thr_ae_up", 3, ae[3], k <= 2);
    end
    idle(); rin[3] = 1;
    for (int k = 7; k >= 0; k--) begin
      step();
      chk("thr_af_dn", 3, af[3], k >= 6);
      chk("thr_ae_dn", 3, ae[3], k <= 2);
    end
    idle();

    // Randomized traffic on all instances
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        vin[i] = ($urandom_range(0, 3) != 0);
        rin[i] = ($urandom_range(0, 2) != 0);
        fin[i] = ($urandom_range(0, 40) == 0);
        din[i] = $urandom;
      end
      step();
    end
    idle();

    // Asynchronous reset mid-operation on u0 at count 3 with a write pending
    fin[0] = 1; step(); idle();
    for (int k = 0; k < 3; k++) begin vin[0] = 1; din[0] = 32'hC0DE0000 + 32'(k); step(); end
    chk("pre_rst_count", 0, cnt(0), 3);
    din[0] = 32'hBADBAD00;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_count", 0, cnt(0), 0);
    chk("rst_data", 0, dout[0], 0);
    idle();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    vin[0] = 1; din[0] = 32'h600DF00D; step();
    idle();
    chk("post_rst_data", 0, dout[0], 32'h600DF00D);
    chk("post_rst_count", 0, cnt(0), 1);
    rin[0] = 1; step();
    chk("post_rst_empty", 0, empty[0], 1);
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
